// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
//
// Shared constants for the core datapath: the machine word width, the ALU
// opcode set, the memory-stage FSM state encoding, the load/store funct3 size
// codes and a couple of small decode helpers used by the memory stage.
//
// Contents (no ports, this is a package):
//   XLEN            machine word width
//   ALU_*           ALU operation codes driven by the decode stage
//   ST_*            memory-stage FSM state encodings
//   F3_*            load/store funct3 codes
//   mem_op_t        per-access bookkeeping carried while a bus access is open
//   misaligned()    address-vs-access-size alignment test
//   size_mask()     unshifted byte-enable mask for an access size
// -----------------------------------------------------------------------------
package mem_stage_pkg;

    localparam int XLEN = 64;

    // ALU operation codes produced by decode and consumed by execute.
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    // Memory-stage FSM states.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Load funct3 codes; bit 2 selects zero extension.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // Store funct3 codes.
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    // What the stage must remember about an access while the bus is busy.
    typedef struct packed {
        logic       is_load;
        logic [2:0] funct3;
        logic [2:0] lane;
        logic       rf_wen;
    } mem_op_t;

    // funct3[1:0] encodes log2 of the access size for both loads and stores,
    // so alignment only needs the low address bits under that size.
    function automatic logic misaligned(input logic [2:0] addr_lo,
                                        input logic [1:0] size_log2);
        logic bad;
        case (size_log2)
            2'd0:    bad = 1'b0;
            2'd1:    bad = addr_lo[0];
            2'd2:    bad = |addr_lo[1:0];
            default: bad = |addr_lo[2:0];
        endcase
        return bad;
    endfunction

    function automatic logic [7:0] size_mask(input logic [1:0] size_log2);
        logic [7:0] m;
        case (size_log2)
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// -----------------------------------------------------------------------------
// load_align
//
// Purely combinational load formatter: picks the addressed bytes out of a
// 64-bit bus word and sign- or zero-extends them to a full register value.
//
// Ports:
//   rdata_i   [63:0]  raw doubleword returned by the data bus
//   lane_i    [2:0]   byte offset of the access within the doubleword
//   funct3_i  [2:0]   load size/sign code (LB..LWU)
//   data_o    [63:0]  register-ready load result (0 for unlisted codes)
// -----------------------------------------------------------------------------
module load_align
    import mem_stage_pkg::*;
(
    input  logic [XLEN-1:0] rdata_i,
    input  logic [2:0]      lane_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] data_o
);

    logic [XLEN-1:0] shifted;

    // Bring the addressed lane down to bit 0, then extend per funct3.
    always_comb begin
        shifted = rdata_i >> {lane_i, 3'b000};
        case (funct3_i)
            F3_LB:   data_o = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
            F3_LH:   data_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_LW:   data_o = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            F3_LD:   data_o = shifted;
            F3_LBU:  data_o = {{(XLEN-8){1'b0}},  shifted[7:0]};
            F3_LHU:  data_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
            F3_LWU:  data_o = {{(XLEN-32){1'b0}}, shifted[31:0]};
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//
// Pipeline memory stage. Non-memory results pass straight through with one
// cycle of latency. Loads and stores are checked for legality, then issued on
// a simple request/ack data bus; the stage stalls execute until the access
// completes, times out, or is rejected as misaligned/illegal.
//
// Parameters:
//   TIMEOUT_CYC   bus cycles to wait for dmem_ack_i before faulting
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   valid_i / ready_o               execute handshake (ready only in IDLE)
//   load_i, store_i, funct3_i       memory-op flags and size/sign code
//   aluout_i                        ALU result or effective address
//   sdata_i                         store data, low-aligned
//   rf_wen_i, rd_i, pc_i, exit_i    writeback/debug sideband
//   dmem_req_o, dmem_we_o           bus request and write enable
//   dmem_addr_o                     doubleword-aligned bus address
//   dmem_wdata_o, dmem_wmask_o      lane-shifted store data and byte mask
//   dmem_ack_i, dmem_rdata_i        bus completion and read data
//   valid_o, rf_wen_o, rd_o,
//   wdata_o, pc_o, exit_o           writeback outputs
//   fault_o                         one-cycle fault flag, qualified by valid_o
// -----------------------------------------------------------------------------
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            valid_i,
    output logic            ready_o,
    input  logic            load_i,
    input  logic            store_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] aluout_i,
    input  logic [XLEN-1:0] sdata_i,
    input  logic            rf_wen_i,
    input  logic [4:0]      rd_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            exit_i,

    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    output logic [7:0]      dmem_wmask_o,
    input  logic            dmem_ack_i,
    input  logic [XLEN-1:0] dmem_rdata_i,

    output logic            valid_o,
    output logic            rf_wen_o,
    output logic [4:0]      rd_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [XLEN-1:0] pc_o,
    output logic            exit_o,
    output logic            fault_o
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [1:0]      state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    mem_op_t         op_q,        op_d;

    logic            bus_we_q,    bus_we_d;
    logic [XLEN-1:0] bus_addr_q,  bus_addr_d;
    logic [XLEN-1:0] bus_wdata_q, bus_wdata_d;
    logic [7:0]      bus_wmask_q, bus_wmask_d;

    logic            valid_q,     valid_d;
    logic            fault_q,     fault_d;
    logic            rf_wen_q,    rf_wen_d;
    logic [XLEN-1:0] wdata_q,     wdata_d;
    logic [4:0]      rd_q,        rd_d;
    logic [XLEN-1:0] pc_q,        pc_d;
    logic            exit_q,      exit_d;

    logic            accept;
    logic            is_mem;
    logic            funct3_bad;
    logic            illegal;
    logic [XLEN-1:0] load_data;

    // Only the byte-lane formatting of read data lives outside this module.
    load_align u_load_align (
        .rdata_i  (dmem_rdata_i),
        .lane_i   (op_q.lane),
        .funct3_i (op_q.funct3),
        .data_o   (load_data)
    );

    // Legality of the incoming op. Loads accept every code except 111,
    // stores only the four sizes; asserting both flags at once is never legal.
    always_comb begin
        accept     = valid_i && (state_q == ST_IDLE);
        is_mem     = load_i || store_i;
        funct3_bad = load_i ? (funct3_i == 3'b111) : funct3_i[2];
        illegal    = (load_i && store_i)
                  || (is_mem && (funct3_bad
                                 || misaligned(aluout_i[2:0], funct3_i[1:0])));
    end

    // Next-state logic. valid_d, fault_d and rf_wen_d default low so that
    // every result pulse lasts exactly one cycle and rf_wen never shows
    // without valid. Bus outputs are captured on acceptance and held
    // untouched until the access ends, then cleared so the bus idles at zero.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_wmask_d = bus_wmask_q;
        valid_d     = 1'b0;
        fault_d     = 1'b0;
        rf_wen_d    = 1'b0;
        wdata_d     = wdata_q;
        rd_d        = rd_q;
        pc_d        = pc_q;
        exit_d      = exit_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    rd_d   = rd_i;
                    pc_d   = pc_i;
                    exit_d = exit_i;
                    if (!is_mem) begin
                        valid_d  = 1'b1;
                        rf_wen_d = rf_wen_i;
                        wdata_d  = aluout_i;
                    end else if (illegal) begin
                        valid_d = 1'b1;
                        fault_d = 1'b1;
                        wdata_d = '0;
                    end else begin
                        state_d        = ST_BUS;
                        cnt_d          = '0;
                        op_d.is_load   = load_i;
                        op_d.funct3    = funct3_i;
                        op_d.lane      = aluout_i[2:0];
                        op_d.rf_wen    = rf_wen_i && load_i;
                        bus_we_d       = store_i;
                        bus_addr_d     = {aluout_i[XLEN-1:3], 3'b000};
                        bus_wdata_d    = store_i ? (sdata_i << {aluout_i[2:0], 3'b000}) : '0;
                        bus_wmask_d    = store_i ? (size_mask(funct3_i[1:0]) << aluout_i[2:0]) : 8'h00;
                    end
                end
            end

            ST_BUS: begin
                // An ack on the final counted cycle still completes normally.
                if (dmem_ack_i) begin
                    state_d     = ST_RESP;
                    valid_d     = 1'b1;
                    rf_wen_d    = op_q.rf_wen;
                    wdata_d     = op_q.is_load ? load_data : '0;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = '0;
                    bus_wdata_d = '0;
                    bus_wmask_d = 8'h00;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = ST_RESP;
                    valid_d     = 1'b1;
                    fault_d     = 1'b1;
                    wdata_d     = '0;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = '0;
                    bus_wdata_d = '0;
                    bus_wmask_d = 8'h00;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // The result registered on leaving BUS is visible here; a late
            // ack arriving now or later is simply not looked at.
            ST_RESP: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers. Reset abandons any open access: the FSM
    // returns to IDLE, so the request drops without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_wmask_q <= 8'h00;
            valid_q     <= 1'b0;
            fault_q     <= 1'b0;
            rf_wen_q    <= 1'b0;
            wdata_q     <= '0;
            rd_q        <= '0;
            pc_q        <= '0;
            exit_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wmask_q <= bus_wmask_d;
            valid_q     <= valid_d;
            fault_q     <= fault_d;
            rf_wen_q    <= rf_wen_d;
            wdata_q     <= wdata_d;
            rd_q        <= rd_d;
            pc_q        <= pc_d;
            exit_q      <= exit_d;
        end
    end

    // Handshake and request decode straight from the state register.
    always_comb begin
        ready_o    = (state_q == ST_IDLE);
        dmem_req_o = (state_q == ST_BUS);
    end

    assign dmem_we_o    = bus_we_q;
    assign dmem_addr_o  = bus_addr_q;
    assign dmem_wdata_o = bus_wdata_q;
    assign dmem_wmask_o = bus_wmask_q;

    assign valid_o  = valid_q;
    assign fault_o  = fault_q;
    assign rf_wen_o = rf_wen_q;
    assign wdata_o  = wdata_q;
    assign rd_o     = rd_q;
    assign pc_o     = pc_q;
    assign exit_o   = exit_q;

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
//
// Self-checking bench for mem_stage (TIMEOUT_CYC = 8). A table of hand-worked
// vectors covers the reference scenarios, a hand-written sequence covers reset
// during a bus access, and a randomized phase is checked against a small
// arithmetic model of the load/store rules.
// -----------------------------------------------------------------------------
module tb_mem_stage;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i, ready_o, load_i, store_i;
    logic [2:0]  funct3_i;
    logic [63:0] aluout_i, sdata_i, pc_i;
    logic        rf_wen_i, exit_i;
    logic [4:0]  rd_i;
    logic        dmem_req_o, dmem_we_o, dmem_ack_i;
    logic [63:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
    logic [7:0]  dmem_wmask_o;
    logic        valid_o, rf_wen_o, exit_o, fault_o;
    logic [4:0]  rd_o;
    logic [63:0] wdata_o, pc_o;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage #(.TIMEOUT_CYC(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .load_i       (load_i),
        .store_i      (store_i),
        .funct3_i     (funct3_i),
        .aluout_i     (aluout_i),
        .sdata_i      (sdata_i),
        .rf_wen_i     (rf_wen_i),
        .rd_i         (rd_i),
        .pc_i         (pc_i),
        .exit_i       (exit_i),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_wmask_o (dmem_wmask_o),
        .dmem_ack_i   (dmem_ack_i),
        .dmem_rdata_i (dmem_rdata_i),
        .valid_o      (valid_o),
        .rf_wen_o     (rf_wen_o),
        .rd_o         (rd_o),
        .wdata_o      (wdata_o),
        .pc_o         (pc_o),
        .exit_o       (exit_o),
        .fault_o      (fault_o)
    );

    always #5 clk = ~clk;

    // One operation: inputs plus everything expected of the DUT for it.
    // delay >= TO means the bus never acknowledges.
    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [63:0] alu;
        logic [63:0] sdata;
        logic [63:0] rdata;
        int          delay;
        logic        rfw;
        logic        e_bus;
        logic        e_fault;
        logic [63:0] e_addr;
        logic        e_we;
        logic [7:0]  e_wmask;
        logic [63:0] e_bwdata;
        logic [63:0] e_res;
        logic        e_rfw;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic ld, logic st, logic [2:0] f3, logic [63:0] alu,
                                logic [63:0] sdata, logic [63:0] rdata, int delay, logic rfw,
                                logic e_bus, logic e_fault, logic [63:0] e_addr, logic e_we,
                                logic [7:0] e_wmask, logic [63:0] e_bwdata,
                                logic [63:0] e_res, logic e_rfw);
        vec_t v;
        v.ld = ld; v.st = st; v.f3 = f3; v.alu = alu; v.sdata = sdata;
        v.rdata = rdata; v.delay = delay; v.rfw = rfw;
        v.e_bus = e_bus; v.e_fault = e_fault; v.e_addr = e_addr; v.e_we = e_we;
        v.e_wmask = e_wmask; v.e_bwdata = e_bwdata; v.e_res = e_res; v.e_rfw = e_rfw;
        return v;
    endfunction

    // Reference model: derives the expected behaviour from the load/store
    // rules with plain arithmetic on sizes, byte offsets and powers of two.
    function automatic vec_t model(vec_t v);
        int          size;
        int          lane;
        logic [63:0] val;
        logic [63:0] lim;
        size = 1 << v.f3[1:0];
        lane = int'(v.alu[2:0]);
        v.e_bus = 0; v.e_fault = 0; v.e_addr = 0; v.e_we = 0;
        v.e_wmask = 0; v.e_bwdata = 0; v.e_res = 0; v.e_rfw = 0;
        if (!v.ld && !v.st) begin
            v.e_res = v.alu;
            v.e_rfw = v.rfw;
            return v;
        end
        if ((v.ld && v.st) || (v.ld && v.f3 == 3'd7) || (v.st && v.f3 > 3'd3)
            || (v.alu % 64'(size) != 0)) begin
            v.e_fault = 1;
            return v;
        end
        v.e_bus  = 1;
        v.e_addr = v.alu - 64'(lane);
        if (v.st) begin
            v.e_we     = 1;
            v.e_wmask  = 8'(((1 << size) - 1) << lane);
            v.e_bwdata = v.sdata << (8 * lane);
        end
        if (v.delay >= TO) begin
            v.e_fault = 1;
            return v;
        end
        if (v.ld) begin
            val = v.rdata >> (8 * lane);
            if (size < 8) begin
                lim = 64'd1 << (8 * size);
                val = val % lim;
                if (v.f3 < 3'd4 && val >= lim / 2) val = val - lim;
            end
            v.e_res = val;
            v.e_rfw = v.rfw;
        end
        return v;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one op for a single accepting cycle, then drop valid.
    task automatic applyStimulus(input vec_t v, input logic [4:0] rd, input logic [63:0] pc,
                                 input logic ex);
        valid_i  = 1'b1;
        load_i   = v.ld;
        store_i  = v.st;
        funct3_i = v.f3;
        aluout_i = v.alu;
        sdata_i  = v.sdata;
        rf_wen_i = v.rfw;
        rd_i     = rd;
        pc_i     = pc;
        exit_i   = ex;
        step;
        valid_i  = 1'b0;
        load_i   = 1'b0;
        store_i  = 1'b0;
        aluout_i = 64'($urandom);
        rd_i     = 5'($urandom);
    endtask

    task automatic run_op(input vec_t v, input int tag);
        logic [4:0]  rd;
        logic [63:0] pc;
        logic        ex;
        bit          done;
        rd   = 5'(tag);
        pc   = 64'h8000_0000 + 64'(tag) * 4;
        ex   = tag[0];
        done = 0;
        checkOutput("ready_before_op", ready_o, 1);
        applyStimulus(v, rd, pc, ex);
        if (!v.e_bus) begin
            checkOutput("no_req", dmem_req_o, 0);
            checkOutput("valid", valid_o, 1);
            checkOutput("fault", fault_o, v.e_fault);
            checkOutput("rf_wen", rf_wen_o, v.e_rfw);
            checkOutput("rd", rd_o, rd);
            checkOutput("pc", pc_o, pc);
            checkOutput("exit", exit_o, ex);
            if (!v.e_fault) checkOutput("wdata", wdata_o, v.e_res);
            step;
            checkOutput("valid_single", valid_o, 0);
        end else begin
            for (int k = 0; k < TO && !done; k++) begin
                checkOutput("req_held", dmem_req_o, 1);
                checkOutput("ready_low", ready_o, 0);
                checkOutput("bus_addr", dmem_addr_o, v.e_addr);
                checkOutput("bus_we", dmem_we_o, v.e_we);
                if (v.st) begin
                    checkOutput("bus_wmask", dmem_wmask_o, v.e_wmask);
                    checkOutput("bus_wdata", dmem_wdata_o, v.e_bwdata);
                end
                if (k == v.delay) begin
                    dmem_ack_i   = 1'b1;
                    dmem_rdata_i = v.rdata;
                end
                step;
                if (k == v.delay) begin
                    dmem_ack_i   = 1'b0;
                    dmem_rdata_i = {$urandom, $urandom};
                    done = 1;
                end
            end
            checkOutput("resp_req_low", dmem_req_o, 0);
            checkOutput("resp_ready_low", ready_o, 0);
            checkOutput("resp_valid", valid_o, 1);
            checkOutput("resp_fault", fault_o, v.e_fault);
            checkOutput("resp_rf_wen", rf_wen_o, v.e_rfw);
            checkOutput("resp_rd", rd_o, rd);
            checkOutput("resp_pc", pc_o, pc);
            checkOutput("resp_exit", exit_o, ex);
            if (v.ld && !v.e_fault) checkOutput("load_data", wdata_o, v.e_res);
            // After a timeout, a late ack must be ignored.
            if (!done) dmem_ack_i = 1'b1;
            step;
            dmem_ack_i = 1'b0;
            checkOutput("post_valid", valid_o, 0);
            checkOutput("post_ready", ready_o, 1);
            checkOutput("post_req", dmem_req_o, 0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;
        int   r;

        rst_n = 1'b0; valid_i = 0; load_i = 0; store_i = 0; funct3_i = 0;
        aluout_i = 0; sdata_i = 0; rf_wen_i = 0; rd_i = 0; pc_i = 0; exit_i = 0;
        dmem_ack_i = 0; dmem_rdata_i = 0;

        // Reference scenarios with hand-worked expected values.
        tbl.push_back(mk(0,0,3'd0,64'h1234,0,0,0,1,                       0,0,0,0,8'h00,0,64'h1234,1));
        tbl.push_back(mk(1,0,3'd0,64'h1003,0,64'h0000_0000_8000_0000,0,1, 1,0,64'h1000,0,8'h00,0,64'hFFFF_FFFF_FFFF_FF80,1));
        tbl.push_back(mk(1,0,3'd4,64'h1003,0,64'h0000_0000_8000_0000,1,1, 1,0,64'h1000,0,8'h00,0,64'h80,1));
        tbl.push_back(mk(0,1,3'd1,64'h2006,64'hBEEF,0,2,1,                 1,0,64'h2000,1,8'hC0,64'hBEEF_0000_0000_0000,0,0));
        tbl.push_back(mk(1,0,3'd2,64'h1002,0,0,0,1,                        0,1,0,0,8'h00,0,0,0));
        tbl.push_back(mk(1,0,3'd3,64'h1000,0,64'h0123_4567_89AB_CDEF,3,1,  1,0,64'h1000,0,8'h00,0,64'h0123_4567_89AB_CDEF,1));
        tbl.push_back(mk(1,0,3'd1,64'h100E,0,64'hFEDC_BA98_7654_3210,0,1,  1,0,64'h1008,0,8'h00,0,64'hFFFF_FFFF_FFFF_FEDC,1));
        tbl.push_back(mk(1,0,3'd5,64'h100E,0,64'hFEDC_BA98_7654_3210,2,1,  1,0,64'h1008,0,8'h00,0,64'hFEDC,1));
        tbl.push_back(mk(1,0,3'd2,64'h1004,0,64'h8765_4321_0000_0000,1,1,  1,0,64'h1000,0,8'h00,0,64'hFFFF_FFFF_8765_4321,1));
        tbl.push_back(mk(1,0,3'd6,64'h1004,0,64'h8765_4321_0000_0000,0,1,  1,0,64'h1000,0,8'h00,0,64'h8765_4321,1));
        tbl.push_back(mk(0,1,3'd0,64'h3005,64'hAA,0,0,1,                   1,0,64'h3000,1,8'h20,64'h0000_AA00_0000_0000,0,0));
        tbl.push_back(mk(0,1,3'd2,64'h3004,64'h1122_3344,0,1,1,            1,0,64'h3000,1,8'hF0,64'h1122_3344_0000_0000,0,0));
        tbl.push_back(mk(0,1,3'd3,64'h3000,64'hCAFE_BABE_DEAD_BEEF,0,4,1,  1,0,64'h3000,1,8'hFF,64'hCAFE_BABE_DEAD_BEEF,0,0));
        tbl.push_back(mk(1,0,3'd7,64'h1000,0,0,0,1,                        0,1,0,0,8'h00,0,0,0));
        tbl.push_back(mk(0,1,3'd4,64'h1000,0,0,0,1,                        0,1,0,0,8'h00,0,0,0));
        tbl.push_back(mk(1,1,3'd3,64'h1000,0,0,0,1,                        0,1,0,0,8'h00,0,0,0));
        tbl.push_back(mk(0,1,3'd3,64'h3004,0,0,0,1,                        0,1,0,0,8'h00,0,0,0));
        tbl.push_back(mk(1,0,3'd3,64'h1000,0,0,99,1,                       1,1,64'h1000,0,8'h00,0,0,0));
        tbl.push_back(mk(0,1,3'd0,64'h3007,64'h5A,0,0,1,                   1,0,64'h3000,1,8'h80,64'h5A00_0000_0000_0000,0,0));

        // Reset values, checked asynchronously before any clock edge.
        #2;
        checkOutput("rst_ready", ready_o, 1);
        checkOutput("rst_req", dmem_req_o, 0);
        checkOutput("rst_valid", valid_o, 0);
        checkOutput("rst_fault", fault_o, 0);
        checkOutput("rst_rf_wen", rf_wen_o, 0);
        checkOutput("rst_wdata", wdata_o, 0);
        checkOutput("rst_addr", dmem_addr_o, 0);
        checkOutput("rst_wmask", dmem_wmask_o, 0);
        step;
        step;
        rst_n = 1'b1;
        step;

        $display("[TB] table vectors");
        for (int i = 0; i < tbl.size(); i++) run_op(tbl[i], i + 5);

        // Reset asserted in the middle of a bus access.
        $display("[TB] reset during bus access");
        v = model(mk(1,0,3'd3,64'h4000,0,0,99,1, 0,0,0,0,8'h00,0,0,0));
        applyStimulus(v, 5'd9, 64'h100, 1'b0);
        checkOutput("mid_req_before_rst", dmem_req_o, 1);
        step;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_req", dmem_req_o, 0);
        checkOutput("mid_rst_ready", ready_o, 1);
        checkOutput("mid_rst_valid", valid_o, 0);
        checkOutput("mid_rst_addr", dmem_addr_o, 0);
        step;
        step;
        rst_n = 1'b1;
        dmem_ack_i = 1'b1;
        step;
        dmem_ack_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("after_rst_valid", valid_o, 0);
            checkOutput("after_rst_req", dmem_req_o, 0);
            step;
        end
        run_op(tbl[0], 5);
        run_op(tbl[5], 6);

        // Randomized ops checked against the model.
        $display("[TB] random vectors");
        for (int n = 0; n < 60; n++) begin
            v.sdata = {$urandom, $urandom};
            v.rdata = {$urandom, $urandom};
            v.alu   = {$urandom, $urandom};
            v.f3    = 3'($urandom_range(0, 7));
            v.rfw   = 1'($urandom);
            r = $urandom_range(0, 9);
            v.ld = (r >= 3 && r <= 5) || r == 9;
            v.st = (r >= 6);
            if ($urandom_range(0, 2) != 0)
                v.alu[2:0] = v.alu[2:0] & ~3'((1 << v.f3[1:0]) - 1);
            v.delay = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 5);
            v = model(v);
            run_op(v, n);
            if ($urandom_range(0, 1) == 1) step;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
